// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: access-size encodings, FSM state
// type, and the alignment rule used by the fault check.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // True when the size/offset pair cannot be served: illegal size or misalignment.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for the data memory: turns a right-aligned store into
// byte strobes plus lane-positioned data, and turns a stored word into a
// right-aligned, sign- or zero-extended load value. Purely combinational.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rword[{addr_lo, 3'b000} +: 8];
  assign rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Strobe/shift for stores and extract/extend for loads, selected by size.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = '0;
    rd_ext   = '0;
    case (size)
      SZ_BYTE: begin
        byte_en  = 4'b0001 << addr_lo;
        wr_lanes = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
        rd_ext   = {{24{sign_ext & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_lanes = addr_lo[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
        rd_ext   = {{16{sign_ext & rd_half[15]}}, rd_half};
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        wr_lanes = wdata;
        rd_ext   = rword;
      end
      default: begin
        byte_en  = 4'b0000;
        wr_lanes = '0;
        rd_ext   = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word access. After reset the
// array is walked once (CLEAR) to zero every word, then requests are
// accepted every cycle (IDLE). Reads return one cycle after accept.
// Optional per-byte even parity is compiled in with DATA_MEM_PARITY_EN.
//
// Handshake: an access is taken on a rising edge where req=1 and ready=1;
// there is no back-pressure beyond ready, and rvalid/err are single-cycle
// pulses in the cycle after accept that the consumer must take as they come.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic              clear_en;
  logic              accept;
  logic              fault;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rword;
  logic [3:0]        byte_en;
  logic [31:0]       wr_lanes;
  logic [31:0]       rd_ext;
  logic              par_bad;

  logic [31:0] mem [DEPTH];

  assign idx    = addr[IDX_W+1:2];
  assign rword  = mem[idx];
  assign accept = req & ready;
  // Any upper index bit set means the word index is at or beyond DEPTH.
  assign fault  = bad_shape(size, addr[1:0]) | (|addr[31:IDX_W+2]);
  assign wr_en  = accept & we & ~fault;

  mem_lane_align u_align (
    .addr_lo  (addr[1:0]),
    .size     (size),
    .sign_ext (sign_ext),
    .wdata    (wdata),
    .rword    (rword),
    .byte_en  (byte_en),
    .wr_lanes (wr_lanes),
    .rd_ext   (rd_ext)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // FSM next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
  end

  // FSM outputs.
  always_comb begin
    ready    = (state_q == ST_IDLE);
    clear_en = (state_q == ST_CLEAR);
  end

  // Clear pointer: one word per cycle while clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (clear_en) cnt_q <= cnt_q + 1'b1;
  end

  // Array write port: zero fill during CLEAR, lane-masked stores in IDLE.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

`ifdef DATA_MEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_now;

  // Recompute parity of the stored word and compare on the lanes being read.
  always_comb begin
    par_now = '0;
    for (int b = 0; b < 4; b++) par_now[b] = ^rword[8*b +: 8];
  end
  assign par_bad = |((par_now ^ par_mem[idx]) & byte_en);

  // Parity write port tracks the data array exactly.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      par_mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) par_mem[idx][b] <= ^wr_lanes[8*b +: 8];
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  // Response register: one-cycle rvalid/err pulses, rdata held between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= accept & ~we;
      err    <= accept & (fault | (~we & par_bad));
      if (accept & ~we) rdata <= fault ? 32'd0 : rd_ext;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem at DEPTH=16: reset/clear timing, load
// extension, lane writes, faults, back-to-back access and random traffic
// against a reference memory model with an expected-response queue.
module tb_data_mem;

  localparam int DEPTH = 16;
  localparam int W     = 34;   // {rvalid, err, rdata}

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [31:0]  model_mem [DEPTH];
  logic [31:0]  last_rdata;
  int           n_checks;
  int           n_errs;

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .size     (size),
    .sign_ext (sign_ext),
    .wdata    (wdata),
    .ready    (ready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic model_fault(input logic [31:0] a, input logic [1:0] s);
    logic f;
    f = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    return f || (a[31:2] >= 30'(DEPTH));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [1:0] s, input logic se);
    logic [31:0] sh;
    sh = w >> {lo, 3'b000};
    case (s)
      2'b00:   return se ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      2'b01:   return se ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Drive one access at the falling edge; on the accept edge, update the
  // model and queue the response expected in the following cycle.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic se, input logic [31:0] d);
    logic        f;
    logic [31:0] wd;
    logic [3:0]  i;
    @(negedge clk);
    check({tag, "_ready"}, ready, 1);
    req = 1'b1; we = w; addr = a; size = s; sign_ext = se; wdata = d;
    @(posedge clk);
    f = model_fault(a, s);
    i = a[5:2];
    if (w) begin
      if (!f) begin
        wd = model_mem[i];
        case (s)
          2'b00:   wd[{a[1:0], 3'b000} +: 8] = d[7:0];
          2'b01:   if (a[1]) wd[31:16] = d[15:0]; else wd[15:0] = d[15:0];
          default: wd = d;
        endcase
        model_mem[i] = wd;
      end
      exp_q.push_back({1'b0, f, last_rdata});
    end else begin
      last_rdata = f ? 32'd0 : model_load(model_mem[i], a[1:0], s, se);
      exp_q.push_back({1'b1, f, last_rdata});
    end
    tag_q.push_back(tag);
  endtask

  task automatic go_idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  // Count rising edges until ready is seen; bounded so a stuck FSM still reports.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    last_rdata = '0;
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < DEPTH; k++) access(tag, 1'b0, 32'(k * 4), 2'b10, 1'b0, '0);
    go_idle();
  endtask

  // Scoreboard: compare queued responses, otherwise expect no pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), {rvalid, err, rdata}, exp_q.pop_front());
      end else begin
        check("idle", {rvalid, err}, 2'b00);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = '0; sign_ext = 1'b0; wdata = '0;
    model_reset();
    #3;
    check("rst_out", {ready, rvalid, err, rdata}, '0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("rel_latency");
    read_all("clr_rd");

    // Word store then byte loads and same-word read-after-write.
    access("sw8",  1'b1, 32'h8, 2'b10, 1'b0, 32'h11223344);
    access("lbB",  1'b0, 32'hB, 2'b00, 1'b0, '0);
    access("lb9",  1'b0, 32'h9, 2'b00, 1'b1, '0);
    access("swC",  1'b1, 32'hC, 2'b10, 1'b0, 32'hA5A5_5A5A);
    access("lwC",  1'b0, 32'hC, 2'b10, 1'b0, '0);
    access("sb5",  1'b1, 32'h5, 2'b00, 1'b0, 32'hFFFF_FF80);
    access("lb5s", 1'b0, 32'h5, 2'b00, 1'b1, '0);
    access("lhu4", 1'b0, 32'h4, 2'b01, 1'b0, '0);
    access("lh4s", 1'b0, 32'h4, 2'b01, 1'b1, '0);
    access("sh6",  1'b1, 32'h6, 2'b01, 1'b0, 32'h0000_F00D);
    access("lw4",  1'b0, 32'h4, 2'b10, 1'b0, '0);

    // Faults: misaligned, illegal size, out of range.
    access("sw0",   1'b1, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D);
    access("lw6",   1'b0, 32'h6, 2'b10, 1'b0, '0);
    access("sh3",   1'b1, 32'h3, 2'b01, 1'b0, 32'h0000_BEEF);
    access("lw0a",  1'b0, 32'h0, 2'b10, 1'b0, '0);
    access("ill",   1'b0, 32'h0, 2'b11, 1'b0, '0);
    access("sw40",  1'b1, 32'h40, 2'b10, 1'b0, 32'h1234_5678);
    access("lw0b",  1'b0, 32'h0, 2'b10, 1'b0, '0);
    access("swhi",  1'b1, 32'h1000_0000, 2'b10, 1'b0, 32'hDEAD_BEEF);
    access("lw0c",  1'b0, 32'h0, 2'b10, 1'b0, '0);
    access("lbhi",  1'b0, 32'h8000_0008, 2'b00, 1'b0, '0);
    go_idle();
    repeat (2) @(negedge clk);

    // Random back-to-back traffic, including faults.
    for (int k = 0; k < 80; k++) begin
      access("rnd", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h47)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end
    go_idle();
    repeat (2) @(negedge clk);

    // Reset right after a read is accepted: the pending response is dropped.
    access("pre_rst", 1'b1, 32'h0, 2'b10, 1'b0, 32'h0BAD_CAFE);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; size = 2'b10;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check("rst_mid", {ready, rvalid, err, rdata}, '0);
    exp_q.delete();
    tag_q.delete();
    model_reset();

    // Release, then pulse reset again after seven clear cycles.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("clr_busy", ready, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_ready("restart_latency");
    read_all("reclr_rd");

    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
